// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state codes, DR select and the IEEE 1149.1 TMS transition graph.
package jtag_pkg;

    localparam int unsigned TAP_STATE_W = 4;
    localparam int unsigned IDCODE_W    = 32;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    function automatic tap_state_t next_tap_state(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        case (state)
            TAP_TLR:     nxt = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   nxt = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   nxt = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: nxt = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   nxt = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   nxt = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   nxt = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: nxt = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   nxt = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR:   nxt = tms ? TAP_SELDR : TAP_RTI;
            default:     nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings TCK/TMS/TDI into the sys_clk domain and flags TCK edges.
module jtag_sync_edge
    import jtag_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic jtag_tck,
    input  logic jtag_tms,
    input  logic jtag_tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [SYNC_STAGES-1:0] tck_sync_q;
    logic [SYNC_STAGES-1:0] tms_sync_q;
    logic [SYNC_STAGES-1:0] tdi_sync_q;
    logic                   tck_prev_q;

    // TMS/TDI use the same depth as TCK so they line up with the detected edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], jtag_tck};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], jtag_tms};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi};
            tck_prev_q <= tck_sync_q[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_sync_q[SYNC_STAGES-1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[SYNC_STAGES-1] & tck_prev_q;
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller in the sys_clk domain: TAP FSM, IR, BYPASS/IDCODE/USER DRs and TDO.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned           IR_W         = 4,
    parameter int unsigned           USER_W       = 8,
    parameter logic [IDCODE_W-1:0]   IDCODE_VAL   = 32'h1AB5_C0DF,
    parameter logic [IR_W-1:0]       INSTR_IDCODE = IR_W'(4'b0001),
    parameter logic [IR_W-1:0]       INSTR_USER   = IR_W'(4'b0010),
    parameter int unsigned           SYNC_STAGES  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              jtag_tck,
    input  logic              jtag_tms,
    input  logic              jtag_tdi,
    output logic              jtag_tdo,
    output logic              tdo_oe,
    output logic [3:0]        tap_state,
    output logic              state_change,
    output logic [IR_W-1:0]   ir_value,
    input  logic [USER_W-1:0] user_dr_in,
    output logic [USER_W-1:0] user_dr_out,
    output logic              user_update
);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    jtag_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    tap_state_t            state_q, state_d, state_prev_q, state_prev_d;
    logic [IR_W-1:0]       ir_shift_q, ir_shift_d, ir_value_q, ir_value_d;
    logic                  bypass_q, bypass_d;
    logic [IDCODE_W-1:0]   idcode_q, idcode_d;
    logic [USER_W-1:0]     user_shift_q, user_shift_d, user_out_q, user_out_d;
    logic                  tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic                  state_change_q, state_change_d, user_update_q, user_update_d;
    dr_sel_t               dr_sel;
    logic                  dr_lsb;

    // All-ones is BYPASS even if it collides with a configured opcode
    always_comb begin
        if (ir_value_q == '1)                dr_sel = DR_BYPASS;
        else if (ir_value_q == INSTR_IDCODE) dr_sel = DR_IDCODE;
        else if (ir_value_q == INSTR_USER)   dr_sel = DR_USER;
        else                                 dr_sel = DR_BYPASS;
    end

    always_comb begin
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_q[0];
            DR_USER:   dr_lsb = user_shift_q[0];
            default:   dr_lsb = bypass_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        state_prev_d   = state_q;
        ir_shift_d     = ir_shift_q;
        ir_value_d     = ir_value_q;
        bypass_d       = bypass_q;
        idcode_d       = idcode_q;
        user_shift_d   = user_shift_q;
        user_out_d     = user_out_q;
        tdo_d          = tdo_q;
        tdo_oe_d       = tdo_oe_q;
        state_change_d = (state_q != state_prev_q);
        user_update_d  = 1'b0;

        if (tck_rise) begin
            state_d = next_tap_state(state_q, tms_s);
            case (state_q)
                TAP_CAPIR: ir_shift_d = IR_W'(2'b01);
                TAP_SHIR:  ir_shift_d = {tdi_s, ir_shift_q[IR_W-1:1]};
                TAP_CAPDR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_d     = IDCODE_VAL;
                        DR_USER:   user_shift_d = user_dr_in;
                        default:   bypass_d     = 1'b0;
                    endcase
                end
                TAP_SHDR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_d     = {tdi_s, idcode_q[IDCODE_W-1:1]};
                        DR_USER:   user_shift_d = (user_shift_q >> 1)
                                                | (USER_W'(tdi_s) << (USER_W-1));
                        default:   bypass_d     = tdi_s;
                    endcase
                end
                default: ;
            endcase
            if (state_d == TAP_TLR) ir_value_d = INSTR_IDCODE;
        end else if (tck_fall) begin
            tdo_d    = 1'b0;
            tdo_oe_d = 1'b0;
            case (state_q)
                TAP_SHIR: begin
                    tdo_d    = ir_shift_q[0];
                    tdo_oe_d = 1'b1;
                end
                TAP_SHDR: begin
                    tdo_d    = dr_lsb;
                    tdo_oe_d = 1'b1;
                end
                TAP_UPDIR: ir_value_d = ir_shift_q;
                TAP_UPDDR: begin
                    if (dr_sel == DR_USER) begin
                        user_out_d    = user_shift_q;
                        user_update_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= TAP_TLR;
            state_prev_q   <= TAP_TLR;
            ir_shift_q     <= '0;
            ir_value_q     <= INSTR_IDCODE;
            bypass_q       <= 1'b0;
            idcode_q       <= '0;
            user_shift_q   <= '0;
            user_out_q     <= '0;
            tdo_q          <= 1'b0;
            tdo_oe_q       <= 1'b0;
            state_change_q <= 1'b0;
            user_update_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            state_prev_q   <= state_prev_d;
            ir_shift_q     <= ir_shift_d;
            ir_value_q     <= ir_value_d;
            bypass_q       <= bypass_d;
            idcode_q       <= idcode_d;
            user_shift_q   <= user_shift_d;
            user_out_q     <= user_out_d;
            tdo_q          <= tdo_d;
            tdo_oe_q       <= tdo_oe_d;
            state_change_q <= state_change_d;
            user_update_q  <= user_update_d;
        end
    end

    assign tap_state    = state_q;
    assign ir_value     = ir_value_q;
    assign user_dr_out  = user_out_q;
    assign jtag_tdo     = tdo_q;
    assign tdo_oe       = tdo_oe_q;
    assign state_change = state_change_q;
    assign user_update  = user_update_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scans, a table-driven state walk and a random TMS/TDI run against a queue model.
`timescale 1ns/1ps
module tb_jtag_tap_ctrl;

    localparam int IR_W   = 4;
    localparam int USER_W = 8;
    localparam logic [31:0] IDC = 32'h1AB5_C0DF;
    localparam int S_EX2DR = 0, S_SHDR = 2, S_UPDDR = 5, S_CAPDR = 6;
    localparam int S_SHIR = 10, S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              jtag_tck = 1'b0, jtag_tms = 1'b0, jtag_tdi = 1'b0;
    logic              jtag_tdo, tdo_oe, state_change, user_update;
    logic [3:0]        tap_state;
    logic [IR_W-1:0]   ir_value;
    logic [USER_W-1:0] user_dr_in = '0;
    logic [USER_W-1:0] user_dr_out;

    jtag_tap_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .jtag_tck     (jtag_tck),
        .jtag_tms     (jtag_tms),
        .jtag_tdi     (jtag_tdi),
        .jtag_tdo     (jtag_tdo),
        .tdo_oe       (tdo_oe),
        .tap_state    (tap_state),
        .state_change (state_change),
        .ir_value     (ir_value),
        .user_dr_in   (user_dr_in),
        .user_dr_out  (user_dr_out),
        .user_update  (user_update)
    );

    always #5 sys_clk = ~sys_clk;

    int sc_cnt = 0;
    int uu_cnt = 0;
    always @(negedge sys_clk) begin
        if (state_change) sc_cnt <= sc_cnt + 1;
        if (user_update)  uu_cnt <= uu_cnt + 1;
    end

    // TMS graph as a lookup table indexed by state code
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int              n_cmp = 0;
    int              n_err = 0;
    int              m_state, m_sc, m_uu;
    logic [IR_W-1:0] m_ir;
    logic [7:0]      m_uout;
    bit              m_tdo, m_oe, last_tdo;
    bit              dr_q[$];
    bit              ir_q[$];

    typedef struct {
        bit         tms;
        bit         tdi;
        logic [3:0] exp_state;
        bit         exp_oe;
    } vec_t;
    vec_t walk [21];
    bit         w_tms [21] = '{0,1,0,0,1,0,1,1,1,1,0,0,1,0,1,1,0,1,1,1,1};
    logic [3:0] w_st  [21] = '{4'hC,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,4'h7,4'h4,4'hE,
                               4'hA,4'h9,4'hB,4'h8,4'hD,4'hC,4'h7,4'h4,4'hF,4'hF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_q(input bit q[$]);
        logic [31:0] r = '0;
        for (int i = 0; i < q.size() && i < 32; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_reset();
        m_state = S_TLR;
        m_ir    = 4'b0001;
        m_uout  = '0;
        m_tdo   = 1'b0;
        m_oe    = 1'b0;
        dr_q.delete();
        ir_q.delete();
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        model_reset();
    endtask

    // One full TCK period; model updated from the rules, DUT checked after each edge settles
    task automatic tck_cyc(input bit tms, input bit tdi);
        int nxt;
        jtag_tms = tms;
        jtag_tdi = tdi;
        jtag_tck = 1'b1;
        case (m_state)
            S_CAPIR: begin
                ir_q.delete();
                ir_q.push_back(1'b1);
                for (int i = 1; i < IR_W; i++) ir_q.push_back(1'b0);
            end
            S_SHIR: begin void'(ir_q.pop_front()); ir_q.push_back(tdi); end
            S_CAPDR: begin
                dr_q.delete();
                if (m_ir == 4'b0001)      for (int i = 0; i < 32; i++) dr_q.push_back(IDC[i]);
                else if (m_ir == 4'b0010) for (int i = 0; i < USER_W; i++) dr_q.push_back(user_dr_in[i]);
                else                      dr_q.push_back(1'b0);
            end
            S_SHDR: begin void'(dr_q.pop_front()); dr_q.push_back(tdi); end
            default: ;
        endcase
        nxt = tms ? nxt1[m_state] : nxt0[m_state];
        if (nxt != m_state) m_sc++;
        m_state = nxt;
        if (m_state == S_TLR) m_ir = 4'b0001;
        repeat (6) @(negedge sys_clk);
        chk("tap_state", 32'(tap_state), 32'(m_state));
        chk("ir_value_rise", 32'(ir_value), 32'(m_ir));

        jtag_tck = 1'b0;
        m_oe  = (m_state == S_SHDR) || (m_state == S_SHIR);
        m_tdo = (m_state == S_SHDR) ? dr_q[0] : (m_state == S_SHIR) ? ir_q[0] : 1'b0;
        if (m_state == S_UPDIR) m_ir = IR_W'(pack_q(ir_q));
        if (m_state == S_UPDDR && m_ir == 4'b0010) begin
            m_uout = 8'(pack_q(dr_q));
            m_uu++;
        end
        repeat (6) @(negedge sys_clk);
        chk("jtag_tdo", 32'(jtag_tdo), 32'(m_tdo));
        chk("tdo_oe", 32'(tdo_oe), 32'(m_oe));
        chk("ir_value_fall", 32'(ir_value), 32'(m_ir));
        chk("user_dr_out", 32'(user_dr_out), 32'(m_uout));
        chk("state_change_count", 32'(sc_cnt), 32'(m_sc));
        chk("user_update_count", 32'(uu_cnt), 32'(m_uu));
        last_tdo = jtag_tdo;
    endtask

    // From RTI: load an IR value, return what was captured, end in RTI
    task automatic load_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] cap);
        tck_cyc(1, 0); tck_cyc(1, 0); tck_cyc(0, 0); tck_cyc(0, 0);
        cap[0] = last_tdo;
        for (int i = 0; i < IR_W; i++) begin
            tck_cyc(i == IR_W-1, val[i]);
            if (i < IR_W-1) cap[i+1] = last_tdo;
        end
        tck_cyc(1, 0); tck_cyc(0, 0);
    endtask

    // From RTI: 8-bit DR scan through Update-DR, end in RTI
    task automatic dr_scan8(input logic [7:0] din, output logic [7:0] dout);
        tck_cyc(1, 0); tck_cyc(0, 0); tck_cyc(0, 0);
        dout[0] = last_tdo;
        for (int i = 0; i < 8; i++) begin
            tck_cyc(i == 7, din[i]);
            if (i < 7) dout[i+1] = last_tdo;
        end
        tck_cyc(1, 0); tck_cyc(0, 0);
    endtask

    initial begin
        logic [31:0]     rd32;
        logic [7:0]      rd8;
        logic [IR_W-1:0] cap;
        int              sc0, uu0;

        for (int i = 0; i < 21; i++)
            walk[i] = '{w_tms[i], 1'b0, w_st[i], (w_st[i] == 4'h2) || (w_st[i] == 4'hA)};

        do_reset();
        m_sc = sc_cnt;
        m_uu = uu_cnt;
        chk("rst_state", 32'(tap_state), 32'hF);
        chk("rst_ir", 32'(ir_value), 32'b0001);
        chk("rst_tdo", 32'(jtag_tdo), 32'd0);
        chk("rst_oe", 32'(tdo_oe), 32'd0);
        chk("rst_user_out", 32'(user_dr_out), 32'd0);
        chk("rst_pulses", 32'({state_change, user_update}), 32'd0);

        sc0 = sc_cnt;
        for (int i = 0; i < 5; i++) tck_cyc(1, 0);
        chk("tlr_hold_state", 32'(tap_state), 32'hF);
        chk("tlr_no_state_change", 32'(sc_cnt - sc0), 32'd0);

        // IDCODE scan, LSB first
        tck_cyc(0, 0); tck_cyc(1, 0); tck_cyc(0, 0); tck_cyc(0, 0);
        rd32[0] = last_tdo;
        for (int i = 1; i < 32; i++) begin
            tck_cyc(0, 0);
            rd32[i] = last_tdo;
        end
        tck_cyc(1, 0); tck_cyc(1, 0); tck_cyc(0, 0);
        chk("idcode_readback", rd32, 32'h1AB5_C0DF);

        // IR all-ones selects BYPASS: one-bit delay
        load_ir(4'b1111, cap);
        chk("ir_capture", 32'(cap), 32'b0001);
        chk("ir_bypass_loaded", 32'(ir_value), 32'hF);
        dr_scan8(8'hA5, rd8);
        chk("bypass_readback", 32'(rd8), 32'h4A);

        // USER register round trip
        load_ir(4'b0010, cap);
        chk("ir_user_loaded", 32'(ir_value), 32'b0010);
        user_dr_in = 8'h3C;
        uu0 = uu_cnt;
        dr_scan8(8'hC3, rd8);
        chk("user_capture_readback", 32'(rd8), 32'h3C);
        chk("user_dr_out_value", 32'(user_dr_out), 32'hC3);
        chk("user_update_one_cycle", 32'(uu_cnt - uu0), 32'd1);

        // Table-driven walk through all 16 states
        for (int i = 0; i < 5; i++) tck_cyc(1, 0);
        sc0 = sc_cnt;
        for (int i = 0; i < 21; i++) begin
            tck_cyc(walk[i].tms, walk[i].tdi);
            chk("walk_state", 32'(tap_state), 32'(walk[i].exp_state));
            chk("walk_oe", 32'(tdo_oe), 32'(walk[i].exp_oe));
        end
        chk("walk_state_changes", 32'(sc_cnt - sc0), 32'd20);

        // Random TMS/TDI/user_dr_in against the model
        for (int i = 0; i < 300; i++) begin
            user_dr_in = 8'($urandom);
            tck_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a USER shift: no update may happen
        do_reset();
        tck_cyc(0, 0);
        load_ir(4'b0010, cap);
        user_dr_in = 8'h5A;
        tck_cyc(1, 0); tck_cyc(0, 0); tck_cyc(0, 0);
        for (int i = 0; i < 3; i++) tck_cyc(0, 1);
        uu0 = uu_cnt;
        sc0 = sc_cnt;
        do_reset();
        chk("midrst_state", 32'(tap_state), 32'hF);
        chk("midrst_user_out", 32'(user_dr_out), 32'd0);
        chk("midrst_oe", 32'(tdo_oe), 32'd0);
        chk("midrst_ir", 32'(ir_value), 32'b0001);
        repeat (4) @(negedge sys_clk);
        chk("midrst_no_update", 32'(uu_cnt - uu0), 32'd0);
        chk("midrst_no_state_change", 32'(sc_cnt - sc0), 32'd0);
        for (int i = 0; i < 3; i++) tck_cyc(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
